// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl
// Sequencing controller and round-robin arbiter for the shared 3-bit
// add/multiply datapath. One requester is granted at a time. Its operands are
// driven to the datapath and the 6-bit result is captured. The result is then
// split into tens/units digits by repeated subtraction of ten. The digits are
// offered on a valid/ready channel to the seven-segment decoders.
//
// Ports
//   iCLK, iRST_N             clock, asynchronous active-low reset
//   iREQ_A/B                 requests, held until granted
//   iOP1_A/B, iOP2_A/B       3-bit operands of each requester
//   iTYPE_A/B                0 = add, 1 = multiply
//   oGNT_A/B                 one-cycle grant pulse
//   oOP1, oOP2, oTYPE        registered operands/type to the datapath
//   iRESULT                  combinational datapath result
//   oDIG_H, oDIG_L           tens / units digit of the captured result
//   oID                      owner of the output (0 = A, 1 = B)
//   oVALID, iREADY           output handshake
//   oBUSY                    high whenever the controller is not idle
module calc_seq_ctrl (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iREQ_A,
  input  logic       iREQ_B,
  input  logic [2:0] iOP1_A,
  input  logic [2:0] iOP2_A,
  input  logic [2:0] iOP1_B,
  input  logic [2:0] iOP2_B,
  input  logic       iTYPE_A,
  input  logic       iTYPE_B,
  input  logic [5:0] iRESULT,
  input  logic       iREADY,
  output logic       oGNT_A,
  output logic       oGNT_B,
  output logic [2:0] oOP1,
  output logic [2:0] oOP2,
  output logic       oTYPE,
  output logic [3:0] oDIG_H,
  output logic [3:0] oDIG_L,
  output logic       oID,
  output logic       oVALID,
  output logic       oBUSY
);

  typedef enum logic [1:0] {IDLE, EXEC, DIV, OUT} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;      // last served requester: 0 = A, 1 = B
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic [2:0] op1_q, op1_d;
  logic [2:0] op2_q, op2_d;
  logic       type_q, type_d;
  logic       id_q, id_d;
  logic [5:0] rem_q, rem_d;
  logic [2:0] tens_q, tens_d;      // up to 6 for unchecked results above 49
  logic [3:0] dig_h_q, dig_h_d;
  logic [3:0] dig_l_q, dig_l_d;
  logic       valid_q, valid_d;
  logic       pick_b;

  // State register and all datapath-facing flops.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      op1_q   <= 3'd0;
      op2_q   <= 3'd0;
      type_q  <= 1'b0;
      id_q    <= 1'b0;
      rem_q   <= 6'd0;
      tens_q  <= 3'd0;
      dig_h_q <= 4'd0;
      dig_l_q <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      type_q  <= type_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
      tens_q  <= tens_d;
      dig_h_q <= dig_h_d;
      dig_l_q <= dig_l_d;
      valid_q <= valid_d;
    end
  end

  // B wins when it is the only requester, or on a tie when A was served last.
  assign pick_b = iREQ_B && (!iREQ_A || !last_q);

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    op1_d   = op1_q;
    op2_d   = op2_q;
    type_d  = type_q;
    id_d    = id_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    dig_h_d = dig_h_q;
    dig_l_d = dig_l_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (iREQ_A || iREQ_B) begin
          id_d    = pick_b;
          last_d  = pick_b;
          gnt_a_d = !pick_b;
          gnt_b_d = pick_b;
          op1_d   = pick_b ? iOP1_B : iOP1_A;
          op2_d   = pick_b ? iOP2_B : iOP2_A;
          type_d  = pick_b ? iTYPE_B : iTYPE_A;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rem_d   = iRESULT;
        tens_d  = 3'd0;
        state_d = DIV;
      end
      DIV: begin
        if (rem_q >= 6'd10) begin
          rem_d  = rem_q - 6'd10;
          tens_d = tens_q + 3'd1;
        end else begin
          dig_h_d = {1'b0, tens_q};
          dig_l_d = rem_q[3:0];
          state_d = OUT;
        end
      end
      OUT: begin
        // The digits sit on the bus for one cycle before valid is raised,
        // so the decoders always see settled digits when valid goes high.
        if (valid_q && iREADY) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign oGNT_A = gnt_a_q;
  assign oGNT_B = gnt_b_q;
  assign oOP1   = op1_q;
  assign oOP2   = op2_q;
  assign oTYPE  = type_q;
  assign oDIG_H = dig_h_q;
  assign oDIG_L = dig_l_q;
  assign oID    = id_q;
  assign oVALID = valid_q;
  assign oBUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl
// Directed bench for calc_seq_ctrl. A table of single-requester jobs with
// hand-computed digits and latencies is followed by hand-written sequences:
// tie after reset, round-robin contention, backpressure and reset mid-DIV.
// The bench supplies the add/multiply datapath for the DUT.
module tb_calc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b;
  logic [2:0] op1_a, op2_a, op1_b, op2_b;
  logic       type_a, type_b;
  logic [5:0] result;
  logic       ready;
  logic       gnt_a, gnt_b;
  logic [2:0] op1, op2;
  logic       typ;
  logic [3:0] dig_h, dig_l;
  logic       id, valid, busy;

  int cycle  = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ra;
    logic [2:0] a1, a2;
    logic       ta;
    logic       rb;
    logic [2:0] b1, b2;
    logic       tb;
    logic       exp_id;
    int         exp_h, exp_l, exp_lat;
  } vec_t;

  vec_t vecs[7];

  calc_seq_ctrl dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iREQ_A(req_a), .iREQ_B(req_b),
    .iOP1_A(op1_a), .iOP2_A(op2_a), .iOP1_B(op1_b), .iOP2_B(op2_b),
    .iTYPE_A(type_a), .iTYPE_B(type_b),
    .iRESULT(result), .iREADY(ready),
    .oGNT_A(gnt_a), .oGNT_B(gnt_b),
    .oOP1(op1), .oOP2(op2), .oTYPE(typ),
    .oDIG_H(dig_h), .oDIG_L(dig_l), .oID(id),
    .oVALID(valid), .oBUSY(busy)
  );

  // Shared datapath driven from the DUT's registered operands.
  assign result = typ ? (6'(op1) * 6'(op2)) : (6'(op1) + 6'(op2));

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Grants must never overlap.
  always @(negedge clk) begin
    if (rst_n && (gnt_a || gnt_b))
      checkOutput("gnt_exclusive", int'(gnt_a && gnt_b), 0);
  end

  task automatic applyStimulus(input vec_t v);
    req_a  = v.ra; op1_a = v.a1; op2_a = v.a2; type_a = v.ta;
    req_b  = v.rb; op1_b = v.b1; op2_b = v.b2; type_b = v.tb;
    ready  = 1'b1;
  endtask

  // Waits for a grant, checks winner, latency, digits and owner, then lets
  // the transfer happen with ready high. With hold set, the winner keeps
  // requesting.
  task automatic runJob(input string tag, input logic exp_id, input int exp_h,
                        input int exp_l, input int exp_lat, input bit hold);
    int  t;
    bit  got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (gnt_a || gnt_b) got = 1'b1;
    end
    if (!got) begin
      checkOutput({tag, "_grant_seen"}, 0, 1);
      return;
    end
    t = cycle;
    checkOutput({tag, "_gnt_a"}, int'(gnt_a), int'(!exp_id));
    checkOutput({tag, "_gnt_b"}, int'(gnt_b), int'(exp_id));
    checkOutput({tag, "_busy"}, int'(busy), 1);
    if (!hold) begin
      if (exp_id) req_b = 1'b0;
      else        req_a = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (i == 0) checkOutput({tag, "_gnt_pulse"}, int'(gnt_a || gnt_b), 0);
      if (valid) got = 1'b1;
    end
    if (!got) begin
      checkOutput({tag, "_valid_seen"}, 0, 1);
      return;
    end
    checkOutput({tag, "_latency"}, cycle - t, exp_lat);
    checkOutput({tag, "_dig_h"}, int'(dig_h), exp_h);
    checkOutput({tag, "_dig_l"}, int'(dig_l), exp_l);
    checkOutput({tag, "_id"}, int'(id), int'(exp_id));
    @(posedge clk); #1;
    checkOutput({tag, "_valid_drop"}, int'(valid), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    bit got;
    // ra a1 a2 ta rb b1 b2 tb id h l lat
    vecs[0] = '{1'b1, 3'd1, 3'd3, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 0, 4, 3}; // 1+3=4
    vecs[1] = '{1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd5, 3'd7, 1'b1, 1'b1, 3, 5, 6}; // 5*7=35
    vecs[2] = '{1'b1, 3'd7, 3'd7, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 4, 9, 7}; // 7*7=49
    vecs[3] = '{1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 0, 0, 3}; // 0+0=0
    vecs[4] = '{1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd7, 3'd7, 1'b0, 1'b1, 1, 4, 4}; // 7+7=14
    vecs[5] = '{1'b1, 3'd2, 3'd5, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1, 0, 4}; // 2*5=10
    vecs[6] = '{1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 0, 9, 3}; // 3*3=9

    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; ready = 1'b0;
    op1_a = 3'd0; op2_a = 3'd0; op1_b = 3'd0; op2_b = 3'd0;
    type_a = 1'b0; type_b = 1'b0;
    #2;
    checkOutput("rst_gnt", int'(gnt_a || gnt_b), 0);
    checkOutput("rst_valid", int'(valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_ops", int'({op1, op2, typ}), 0);
    checkOutput("rst_digits", int'({dig_h, dig_l, id}), 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;

    // Table of single-requester jobs.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      runJob($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_h,
             vecs[i].exp_l, vecs[i].exp_lat, 1'b0);
    end

    // Simultaneous requests straight after reset: A wins the first tie.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req_a = 1'b1; op1_a = 3'd2; op2_a = 3'd3; type_a = 1'b1;
    req_b = 1'b1; op1_b = 3'd7; op2_b = 3'd7; type_b = 1'b0;
    ready = 1'b1;
    runJob("tie_a", 1'b0, 0, 6, 3, 1'b0);
    runJob("tie_b", 1'b1, 1, 4, 4, 1'b0);

    // Sustained contention: grants alternate starting with A (B served last).
    req_a = 1'b1; op1_a = 3'd1; op2_a = 3'd2; type_a = 1'b0;
    req_b = 1'b1; op1_b = 3'd3; op2_b = 3'd2; type_b = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j % 2 == 0) runJob($sformatf("rr%0d", j), 1'b0, 0, 3, 3, 1'b1);
      else            runJob($sformatf("rr%0d", j), 1'b1, 0, 6, 3, 1'b1);
    end
    req_a = 1'b0; req_b = 1'b0;

    // Backpressure on 6*5 = 30.
    req_a = 1'b1; op1_a = 3'd6; op2_a = 3'd5; type_a = 1'b1;
    ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (gnt_a || gnt_b) got = 1'b1;
    end
    checkOutput("bp_grant", int'(gnt_a), 1);
    t = cycle;
    req_a = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (valid) got = 1'b1;
    end
    checkOutput("bp_latency", cycle - t, 6);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp_valid%0d", k), int'(valid), 1);
      checkOutput($sformatf("bp_dig%0d", k), int'({dig_h, dig_l}), 8'h30);
      checkOutput($sformatf("bp_id%0d", k), int'(id), 0);
      if (k < 4) begin @(posedge clk); #1; end
    end
    ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_valid_drop", int'(valid), 0);
    checkOutput("bp_busy_drop", int'(busy), 0);

    // Reset in the middle of dividing 7*7, with B waiting.
    req_a = 1'b1; op1_a = 3'd7; op2_a = 3'd7; type_a = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (gnt_a || gnt_b) got = 1'b1;
    end
    checkOutput("mid_grant", int'(gnt_a), 1);
    req_a = 1'b0;
    req_b = 1'b1; op1_b = 3'd2; op2_b = 3'd5; type_b = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("mid_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_valid", int'(valid), 0);
    checkOutput("mid_rst_gnt", int'(gnt_a || gnt_b), 0);
    checkOutput("mid_rst_ops", int'({op1, op2, typ}), 0);
    checkOutput("mid_rst_digits", int'({dig_h, dig_l, id}), 0);
    #2 rst_n = 1'b1;
    runJob("mid_b", 1'b1, 0, 7, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Sequencing controller and two-port arbiter for the shared 3-bit add/multiply datapath. Two requesters each present an operand pair and an operation type. The block grants one requester at a time in round-robin order, drives the datapath and captures its 6-bit result. It then splits the result into tens/units BCD digits by iterative subtraction and offers them on a valid/ready output channel that feeds the two seven-segment digit decoders.

## Interface
- No parameters; all widths fixed (operands 3 bits, result 6 bits, digits 4 bits).
- iCLK  in  1  single clock; all state changes on its rising edge
- iRST_N  in  1  asynchronous, active-low reset
- iREQ_A / iREQ_B  in  1  request from requester A / B; held until granted
- iOP1_A, iOP2_A / iOP1_B, iOP2_B  in  3  operands; stable while the matching iREQ is high
- iTYPE_A / iTYPE_B  in  1  operation type: 0 = add, 1 = multiply
- oGNT_A / oGNT_B  out  1  one-cycle pulse; request accepted and operands latched
- oOP1, oOP2  out  3  operands driven to the datapath (registered)
- oTYPE  out  1  operation type driven to the datapath (registered)
- iRESULT  in  6  combinational datapath result for oOP1/oOP2/oTYPE
- oDIG_H, oDIG_L  out  4  tens / units digit of the captured result
- oID  out  1  requester that owns the current output: 0 = A, 1 = B
- oVALID  out  1  digits and oID are valid
- iREADY  in  1  consumer accepts the output when high together with oVALID
- oBUSY  out  1  high in every state except IDLE

## Operation
- States: IDLE, EXEC, DIV, OUT.
- **IDLE**
  - On an edge with any iREQ high:
    - Pick the winner.
    - Latch the winner's iOP1/iOP2/iTYPE into oOP1/oOP2/oTYPE.
    - Set oID to the winner.
    - Pulse that requester's oGNT for the next cycle.
    - Go to EXEC.
  - With no request, stay in IDLE.
- **Arbitration**
  - Only one request high: that requester wins.
  - Both high: the requester not served last wins.
  - The last-served pointer resets to B, so A wins the first tie.
  - The pointer updates at grant.
- **EXEC**
  - Operands are held; the datapath settles.
  - At the end of the cycle, latch iRESULT into the remainder register, clear tens to 0 and go to DIV.
- **DIV**
  - While remainder ≥ 10: remainder −= 10 and tens += 1, one step per cycle.
  - When remainder < 10: oDIG_H = tens, oDIG_L = remainder, go to OUT.
- **OUT**
  - oVALID = 1.
  - oDIG_H, oDIG_L and oID are held stable until the transfer.
  - On an edge with iREADY = 1, go to IDLE.
- **Width rules**
  - Datapath result range is 0..49: add gives at most 14, multiply at most 49.
  - Tens is always 0..4 and units 0..9.
  - The controller does not check iRESULT values above 49. Any 6-bit value still terminates, giving tens ≤ 6.
- **Request handling**
  - iREQ is ignored outside IDLE; an unserved request waits.
  - A request dropped before its grant is withdrawn silently.
  - iREADY is ignored outside OUT.

## Timing
- Reset values:
  - oGNT_A = oGNT_B = 0, oVALID = 0, oBUSY = 0
  - oOP1 = oOP2 = 0, oTYPE = 0
  - oDIG_H = oDIG_L = 0, oID = 0
  - State = IDLE, last-served pointer = B.
- **Grant**
  - The accepting edge is T.
  - oGNT and oBUSY are high in the cycle after T; oGNT drops after one cycle.
- **Latency** for result R:
  - oVALID rises 3 + floor(R/10) edges after T.
  - Minimum: 3 (R < 10). Maximum: 7 (R = 49).
- **Output transfer**
  - The transfer occurs on the first edge with oVALID and iREADY both high.
  - oVALID falls on that edge.
  - If iREADY is already high when oVALID rises, oVALID lasts exactly one cycle.
- **Throughput**
  - The next grant is no earlier than the edge after the return to IDLE, so there is at least one IDLE cycle between jobs.
- **Outputs between jobs**
  - oDIG_H, oDIG_L and oID keep their last values in IDLE.
  - oVALID alone qualifies them.
- **Reset mid-operation**
  - iRST_N low in any state forces all reset values immediately, without waiting for a clock edge.
  - In-flight operands and results are discarded and no grant is repeated.
  - Requesters still holding iREQ are re-arbitrated from the reset pointer.

## Test plan
- **Reset then single request**
  - Stimulus: A: 1+3 (type 0), iREADY = 1.
  - Required: oGNT_A pulses 1 cycle; oVALID at T+3; oDIG_H = 0, oDIG_L = 4, oID = 0.
- **Multiply latency**
  - Stimulus: B: 5×7.
  - Required: oGNT_B pulses; oVALID at T+6; digits 3/5, oID = 1.
  - Stimulus: 7×7.
  - Required: oVALID at T+7; digits 4/9.
- **Simultaneous requests after reset**
  - Stimulus: A: 2×3, B: 7+7, both held.
  - Required: A served first (digits 0/6, oID = 0); then B (digits 1/4, oID = 1). Never both oGNT high.
- **Round-robin under sustained contention**
  - Stimulus: both requests re-asserted after every grant, over 6 jobs.
  - Required: grants alternate A, B, A, B, A, B.
- **Backpressure**
  - Stimulus: iREADY low for 5 cycles after oVALID rises for 6×5.
  - Required: oVALID stays high with digits 3/0 and oID stable; the transfer occurs on the first edge with iREADY high; oBUSY = 0 the next cycle.
- **Reset mid-DIV**
  - Stimulus: assert iRST_N low 3 cycles after granting A: 7×7.
  - Required: all outputs go to reset values with no clock edge needed. After release with B: 2+5 pending, B is granted and gives digits 0/7.
